// File: rtl/rx_fifo_avalon_if.sv
// Avalon-MM slave bus plus the UART RX load side and interrupt line of the RX FIFO.
// The master side is whoever drives the bus and the deserialiser strobe.
interface rx_fifo_avalon_if #(
    parameter int DATA_W = 9
);
    logic [1:0]        address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] RX_data;
    logic              load;
    logic              irq;

    modport master (
        output address, chipselect, read, write, writedata, RX_data, load,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata, RX_data, load,
        output readdata, irq
    );
endinterface

// File: rtl/rx_fifo_avalon.sv
// DEPTH-entry receive FIFO between the UART RX deserialiser and an Avalon-MM slave port,
// with status/count, sticky overrun, threshold interrupt and software flush.
module rx_fifo_avalon #(
    parameter  int DATA_W = 9,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    rx_fifo_avalon_if.slave  bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              overrun;
    logic              overrun_next;
    logic              irq_en;
    logic [7:0]        threshold;
    logic              irq_next;
    logic              thr_hit;

    logic              bus_wr;
    logic              bus_rd;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              flush;
    logic              ovr_set;
    logic              ovr_clr;

    logic [31:0]       rd_word_p0;
    logic [31:0]       readdata_p1;
    logic              irq_p1;
    logic              unused_wdata;

    // A threshold of zero would fire permanently, so it is promoted to one.
    function automatic logic [7:0] norm_threshold(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    assign unused_wdata = ^{bus.writedata[31:16], bus.writedata[7:2]};

    always_comb begin
        bus_wr  = bus.chipselect & bus.write;
        bus_rd  = bus.chipselect & bus.read & ~bus.write;
        empty   = (count == '0);
        full    = (count == (PTR_W+1)'(DEPTH));
        pop     = bus_rd & (bus.address == 2'd0) & ~empty;
        flush   = bus_wr & (bus.address == 2'd3) & bus.writedata[0];
        ovr_clr = bus_wr & (bus.address == 2'd3) & bus.writedata[1];
        push    = bus.load & ~flush & (~full | pop);
        ovr_set = bus.load & ~flush & full & ~pop;

        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (PTR_W+1)'(1);
        end

        overrun_next = ovr_set | (overrun & ~ovr_clr);
        thr_hit      = (9'(count_next) >= 9'(threshold));
        irq_next     = irq_en & (thr_hit | overrun_next);
    end

    // Stage p0: read mux, zero whenever the cycle carries no valid read.
    always_comb begin
        rd_word_p0 = '0;
        if (bus_rd) begin
            case (bus.address)
                2'd0: begin
                    if (!empty) begin
                        rd_word_p0[DATA_W-1:0] = mem[rd_ptr];
                        rd_word_p0[DATA_W]     = 1'b1;
                    end
                end
                2'd1: begin
                    rd_word_p0[0]           = empty;
                    rd_word_p0[1]           = full;
                    rd_word_p0[2]           = overrun;
                    rd_word_p0[3]           = irq_p1;
                    rd_word_p0[8 +: PTR_W+1] = count;
                end
                2'd2: begin
                    rd_word_p0[0]    = irq_en;
                    rd_word_p0[15:8] = threshold;
                end
                default: rd_word_p0 = '0;
            endcase
        end
    end

    // Stage p1: registered control state and bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            irq_en      <= 1'b0;
            threshold   <= 8'd1;
            irq_p1      <= 1'b0;
            readdata_p1 <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            overrun     <= overrun_next;
            irq_p1      <= irq_next;
            readdata_p1 <= rd_word_p0;
            if (bus_wr && bus.address == 2'd2) begin
                irq_en    <= bus.writedata[0];
                threshold <= norm_threshold(bus.writedata[15:8]);
            end
        end
    end

    // Storage is left unreset; stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.RX_data;
    end

    assign bus.readdata = readdata_p1;
    assign bus.irq      = irq_p1;

endmodule

// File: tb/tb_rx_fifo_avalon.sv
// Randomised and directed bench for rx_fifo_avalon; a queue-based reference model feeds
// a scoreboard that a negedge monitor drains against readdata and irq.
module tb_rx_fifo_avalon;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_fifo_avalon_if #(.DATA_W(DATA_W)) bus ();

    rx_fifo_avalon #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mq[$];
    bit   m_ovr;
    bit   m_irq_en;
    bit   m_irq;
    int   m_thr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr    = 0;
        m_irq_en = 0;
        m_irq    = 0;
        m_thr    = 1;
    endtask

    task automatic drive_idle();
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'd0;
        bus.RX_data    = '0;
        bus.load       = 1'b0;
    endtask

    // One bus cycle: drive, then advance the model and queue what the DUT must show after the edge.
    task automatic cyc(input logic [1:0] a, input bit cs, input bit rd, input bit wr,
                       input logic [31:0] wd, input bit ld, input logic [DATA_W-1:0] rx,
                       input string tag);
        exp_t        e;
        bit          bw, br, popd, flush, ovs;
        logic [31:0] exp;
        @(negedge clk);
        #1;
        bus.address    = a;
        bus.chipselect = cs;
        bus.read       = rd;
        bus.write      = wr;
        bus.writedata  = wd;
        bus.load       = ld;
        bus.RX_data    = rx;

        bw   = cs && wr;
        br   = cs && rd && !wr;
        exp  = 32'd0;
        popd = 0;
        if (br) begin
            case (a)
                2'd0: if (mq.size() > 0) begin
                    exp  = 32'(mq[0]) | (32'd1 << DATA_W);
                    popd = 1;
                end
                2'd1: exp = {16'd0, 8'(mq.size()), 4'd0, m_irq, m_ovr,
                             (mq.size() == DEPTH), (mq.size() == 0)};
                2'd2: exp = {16'd0, 8'(m_thr), 7'd0, m_irq_en};
                default: exp = 32'd0;
            endcase
        end
        if (popd) void'(mq.pop_front());
        flush = bw && (a == 2'd3) && wd[0];
        ovs   = 0;
        if (flush) mq.delete();
        else if (ld) begin
            if (mq.size() < DEPTH) mq.push_back(rx);
            else ovs = 1;
        end
        if (ovs) m_ovr = 1;
        else if (bw && (a == 2'd3) && wd[1]) m_ovr = 0;
        m_irq = m_irq_en && ((mq.size() >= m_thr) || m_ovr);
        if (bw && (a == 2'd2)) begin
            m_irq_en = wd[0];
            m_thr    = (wd[15:8] == 8'd0) ? 1 : int'(wd[15:8]);
        end
        e.rd  = exp;
        e.irq = m_irq;
        e.tag = tag;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'd0, 0, 0, 0, 32'd0, 0, '0, "idle");
    endtask

    task automatic rd_reg(input logic [1:0] a, input string tag);
        cyc(a, 1, 1, 0, 32'd0, 0, '0, tag);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input string tag);
        cyc(a, 1, 0, 1, wd, 0, '0, tag);
    endtask

    task automatic ld_word(input logic [DATA_W-1:0] rx, input string tag);
        cyc(2'd0, 0, 0, 0, 32'd0, 1, rx, tag);
    endtask

    task automatic drain_monitor();
        @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && expq.size() > 0) begin
            e = expq.pop_front();
            chk(e.tag, bus.readdata, e.rd);
            chk({e.tag, "_irq"}, 32'(bus.irq), 32'(e.irq));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ld_pct;
        logic [1:0]  a;
        logic [31:0] wd;
        drive_idle();
        model_reset();
        #3;
        chk("reset_readdata", bus.readdata, 32'd0);
        chk("reset_irq", 32'(bus.irq), 32'd0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        rd_reg(2'd1, "status_after_reset");
        rd_reg(2'd0, "data_empty");
        rd_reg(2'd1, "status_still_empty");

        ld_word(9'h0A5, "load_a5");
        ld_word(9'h1FF, "load_1ff");
        rd_reg(2'd0, "data_a5");
        rd_reg(2'd0, "data_1ff");
        rd_reg(2'd1, "status_empty_again");

        for (int i = 1; i <= DEPTH + 1; i++) ld_word(DATA_W'(i), "fill_overrun");
        rd_reg(2'd1, "status_full_overrun");
        for (int i = 0; i <= DEPTH; i++) rd_reg(2'd0, "drain_in_order");
        wr_reg(2'd3, 32'h2, "clear_overrun");
        rd_reg(2'd1, "status_overrun_cleared");

        for (int i = 0; i < DEPTH; i++) ld_word(DATA_W'(9'h40 + i), "fill_full");
        cyc(2'd0, 1, 1, 0, 32'd0, 1, 9'h155, "full_pop_with_load");
        rd_reg(2'd1, "status_full_no_overrun");
        for (int i = 0; i < DEPTH; i++) rd_reg(2'd0, "drain_wrap");
        rd_reg(2'd1, "status_after_wrap");

        wr_reg(2'd2, 32'h0000_0301, "ctrl_thr3");
        rd_reg(2'd2, "ctrl_readback");
        ld_word(9'h011, "thr_load1");
        ld_word(9'h022, "thr_load2");
        idle(1);
        ld_word(9'h033, "thr_load3");
        idle(1);
        rd_reg(2'd0, "thr_pop_to_2");
        idle(1);

        ld_word(9'h044, "flush_load_a");
        ld_word(9'h055, "flush_load_b");
        ld_word(9'h066, "flush_load_c");
        rd_reg(2'd1, "status_five");
        cyc(2'd3, 1, 0, 1, 32'h1, 1, 9'h0EE, "flush_with_load");
        rd_reg(2'd1, "status_after_flush");
        wr_reg(2'd2, 32'h0000_0000, "ctrl_thr0");
        rd_reg(2'd2, "ctrl_thr0_readback");
        cyc(2'd0, 1, 1, 1, 32'h0, 1, 9'h077, "rd_wr_collision");
        rd_reg(2'd1, "status_collision");

        for (int phase = 0; phase < 3; phase++) begin
            ld_pct = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
            for (int i = 0; i < 600; i++) begin
                a  = 2'($urandom_range(0, 3));
                wd = $urandom;
                wd[15:8] = 8'($urandom_range(0, 20));
                if (a == 2'd3 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
                cyc(a, ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, wd, ($urandom_range(0, 99) < ld_pct),
                    DATA_W'($urandom), "random");
            end
        end

        wr_reg(2'd3, 32'h3, "pre_reset_clear");
        wr_reg(2'd2, 32'h0000_0301, "pre_reset_ctrl");
        for (int i = 0; i < 5; i++) ld_word(DATA_W'(9'h100 + i), "pre_reset_load");
        rd_reg(2'd1, "status_pre_reset");
        drain_monitor();
        drive_idle();
        reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", bus.readdata, 32'd0);
        chk("async_reset_irq", 32'(bus.irq), 32'd0);
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;
        rd_reg(2'd1, "status_post_reset");
        rd_reg(2'd2, "ctrl_post_reset");
        rd_reg(2'd0, "data_post_reset");
        idle(1);
        drain_monitor();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
